// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns an ALU effective address plus rs2 into one word-wide
// req/ready bus access, with lane steering, load extension, alignment and timeout checks.
//
// state | meaning
// IDLE  | waiting for start with a load or store
// REQ   | bus_req held until bus_ready or timeout
// DONE  | one-cycle completion pulse; status flags valid
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    // Down-counter reaches zero on the last allowed wait cycle.
    localparam logic [15:0] TIMER_LOAD = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [1:0]  byte_off;
    logic [2:0]  funct3_q;
    logic [15:0] timer;

    logic        accept;
    logic        illegal;
    logic        misal;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;

    always_comb begin
        accept = (state == IDLE) && start && (mem_read || mem_write);
        busy   = accept || (state == REQ);

        illegal = 1'b0;
        if (mem_read && mem_write) begin
            illegal = 1'b1;
        end else if (mem_read) begin
            illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end else begin
            illegal = !(funct3 inside {3'b000, 3'b001, 3'b010});
        end

        misal = 1'b0;
        if (funct3[1:0] == 2'b01) misal = addr[0];
        else if (funct3[1:0] == 2'b10) misal = (addr[1:0] != 2'b00);

        store_be    = 4'b1111;
        store_wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                store_be    = 4'b0001 << addr[1:0];
                store_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                store_be    = 4'b0011 << {addr[1], 1'b0};
                store_wdata = {2{store_data[15:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = store_data;
            end
        endcase

        case (byte_off)
            2'b00:   rd_byte = bus_rdata[7:0];
            2'b01:   rd_byte = bus_rdata[15:8];
            2'b10:   rd_byte = bus_rdata[23:16];
            default: rd_byte = bus_rdata[31:24];
        endcase
        rd_half = byte_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];

        case (funct3_q)
            3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_ext = {24'h0, rd_byte};
            3'b101:  load_ext = {16'h0, rd_half};
            default: load_ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            byte_off   <= 2'b00;
            funct3_q   <= 3'b000;
            timer      <= 16'h0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            fault      <= 1'b0;
            load_data  <= 32'h0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'h0;
            bus_wdata  <= 32'h0;
            bus_be     <= 4'h0;
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            fault      <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        byte_off <= addr[1:0];
                        funct3_q <= funct3;
                        if (illegal) begin
                            state <= DONE;
                            done  <= 1'b1;
                            fault <= 1'b1;
                        end else if (misal) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            misaligned <= 1'b1;
                        end else begin
                            state     <= REQ;
                            timer     <= TIMER_LOAD;
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= mem_write ? store_be : 4'b1111;
                            bus_wdata <= mem_write ? store_wdata : 32'h0;
                        end
                    end
                end
                REQ: begin
                    if (bus_ready || timer == 16'h0) begin
                        if (bus_ready && !bus_we) load_data <= load_ext;
                        fault     <= !bus_ready;
                        state     <= DONE;
                        done      <= 1'b1;
                        timer     <= 16'h0;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= 32'h0;
                        bus_wdata <= 32'h0;
                        bus_be    <= 4'h0;
                    end else begin
                        timer <= timer - 16'h1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed ops push expected bus requests and
// completions into queues; negedge monitors pop and compare what the DUT presents.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        busy, done, misaligned, fault;
    logic [31:0] load_data;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .addr(addr), .store_data(store_data),
        .busy(busy), .done(done), .load_data(load_data), .misaligned(misaligned),
        .fault(fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ready(bus_ready),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ld;
        logic        mis;
        logic        flt;
    } resp_t;

    typedef struct {
        logic [31:0] a;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
    } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];

    int vectors = 0;
    int miscompares = 0;

    int  wait_n = 0;
    bit  hold_low = 1'b0;
    int  req_cycles = 0;
    logic        prev_req = 1'b0;
    bus_t        cur_bus;
    logic [31:0] cur_ld = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void expect_resp(input logic [31:0] ld, input logic mis, input logic flt);
        resp_t r;
        r.ld = ld; r.mis = mis; r.flt = flt;
        resp_q.push_back(r);
    endfunction

    function automatic void expect_bus(input logic [31:0] a, input logic we,
                                       input logic [3:0] be, input logic [31:0] wd);
        bus_t b;
        b.a = a; b.we = we; b.be = be; b.wd = wd;
        bus_q.push_back(b);
    endfunction

    // Bus slave: ready after wait_n stall cycles unless held low.
    always @(negedge clk) begin
        if (bus_req) begin
            bus_ready = (!hold_low && req_cycles == wait_n);
            req_cycles++;
        end else begin
            bus_ready  = 1'b0;
            req_cycles = 0;
        end
    end

    // Completion monitor.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'h0);
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    chk("load_data", load_data, r.ld);
                    chk("misaligned", 32'(misaligned), 32'(r.mis));
                    chk("fault", 32'(fault), 32'(r.flt));
                end
            end else if (misaligned || fault) begin
                chk("flags_outside_done", {30'h0, misaligned, fault}, 32'h0);
            end
        end
    end

    // Bus monitor: request contents, stability while held, quiet bus otherwise.
    always @(negedge clk) begin
        if (bus_req && !prev_req) begin
            if (bus_q.size() == 0) begin
                chk("unexpected_bus_req", 32'(bus_req), 32'h0);
            end else begin
                cur_bus = bus_q.pop_front();
                chk("bus_addr", bus_addr, cur_bus.a);
                chk("bus_we", 32'(bus_we), 32'(cur_bus.we));
                chk("bus_be", 32'(bus_be), 32'(cur_bus.be));
                chk("bus_wdata", bus_wdata, cur_bus.wd);
            end
        end else if (bus_req) begin
            chk("bus_stable", {bus_addr[31:2], bus_we, 1'b0} ^ {bus_wdata[31:4], bus_be},
                {cur_bus.a[31:2], cur_bus.we, 1'b0} ^ {cur_bus.wd[31:4], cur_bus.be});
        end else if (bus_we || bus_be != 4'h0 || bus_addr != 32'h0 || bus_wdata != 32'h0) begin
            chk("bus_idle_zero", {bus_addr[31:5], bus_we, bus_be} | bus_wdata, 32'h0);
        end
        prev_req = bus_req;
    end

    task automatic do_op(input string name, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rdata, input int wn, input bit hold,
                         input int exp_lat, input int exp_req);
        int n = 0;
        int busy_n = 0;
        int req_n = 0;
        bit got = 1'b0;
        @(posedge clk);
        #1;
        wait_n = wn; hold_low = hold; bus_rdata = rdata;
        start = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
        #1;
        busy_n += int'(busy);
        while (n < 50 && !got) begin
            @(posedge clk);
            #1;
            start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
            #1;
            n++;
            busy_n += int'(busy);
            if (bus_req) req_n++;
            got = done;
        end
        if (!got) chk({name, "_timeout"}, 32'(n), 32'(exp_lat));
        else chk({name, "_latency"}, 32'(n), 32'(exp_lat));
        chk({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat));
        chk({name, "_req_cycles"}, 32'(req_n), 32'(exp_req));
        hold_low = 1'b0;
        wait_n = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'b0; addr = 32'h0; store_data = 32'h0;
        bus_ready = 1'b0; bus_rdata = 32'h0;
        #12;
        chk("reset_outputs", {busy, done, misaligned, fault, bus_req, bus_we, bus_be},
            32'h0);
        chk("reset_load_data", load_data, 32'h0);
        chk("reset_bus_addr", bus_addr | bus_wdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        expect_bus(32'h100, 1'b0, 4'b1111, 32'h0);
        cur_ld = 32'hDEADBEEF; expect_resp(cur_ld, 1'b0, 1'b0);
        do_op("lw", 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 2, 1);

        expect_bus(32'h100, 1'b0, 4'b1111, 32'h0);
        cur_ld = 32'hFFFFFF80; expect_resp(cur_ld, 1'b0, 1'b0);
        do_op("lb", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 2, 1);

        expect_bus(32'h100, 1'b0, 4'b1111, 32'h0);
        cur_ld = 32'h00000080; expect_resp(cur_ld, 1'b0, 1'b0);
        do_op("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 2, 1);

        expect_bus(32'h100, 1'b0, 4'b1111, 32'h0);
        cur_ld = 32'hFFFF80FF; expect_resp(cur_ld, 1'b0, 1'b0);
        do_op("lh", 1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 0, 0, 2, 1);

        expect_bus(32'h100, 1'b0, 4'b1111, 32'h0);
        cur_ld = 32'h000080FF; expect_resp(cur_ld, 1'b0, 1'b0);
        do_op("lhu", 1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 0, 0, 2, 1);

        expect_bus(32'h100, 1'b1, 4'b0010, 32'hABABABAB);
        expect_resp(cur_ld, 1'b0, 1'b0);
        do_op("sb", 0, 1, 3'b000, 32'h101, 32'h000000AB, 32'h0, 0, 0, 2, 1);

        expect_bus(32'h100, 1'b1, 4'b1100, 32'h12341234);
        expect_resp(cur_ld, 1'b0, 1'b0);
        do_op("sh", 0, 1, 3'b001, 32'h102, 32'hFFFF1234, 32'h0, 0, 0, 2, 1);

        expect_bus(32'h204, 1'b1, 4'b1111, 32'hCAFEF00D);
        expect_resp(cur_ld, 1'b0, 1'b0);
        do_op("sw", 0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 1, 0, 3, 2);

        expect_resp(cur_ld, 1'b1, 1'b0);
        do_op("lw_misaligned", 1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0, 1, 0);

        expect_resp(cur_ld, 1'b1, 1'b0);
        do_op("lh_misaligned", 1, 0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0, 1, 0);

        expect_resp(cur_ld, 1'b0, 1'b1);
        do_op("store_f3_011", 0, 1, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 1, 0);

        expect_resp(cur_ld, 1'b0, 1'b1);
        do_op("store_f3_100", 0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 0, 1, 0);

        expect_resp(cur_ld, 1'b0, 1'b1);
        do_op("load_f3_110", 1, 0, 3'b110, 32'h100, 32'h0, 32'h0, 0, 0, 1, 0);

        expect_resp(cur_ld, 1'b0, 1'b1);
        do_op("rd_and_wr", 1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0, 0, 1, 0);

        expect_bus(32'h100, 1'b0, 4'b1111, 32'h0);
        cur_ld = 32'h0000007F; expect_resp(cur_ld, 1'b0, 1'b0);
        do_op("lb_odd", 1, 0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 0, 0, 2, 1);

        expect_bus(32'h300, 1'b0, 4'b1111, 32'h0);
        expect_resp(cur_ld, 1'b0, 1'b1);
        do_op("timeout", 1, 0, 3'b010, 32'h300, 32'h0, 32'h11111111, 0, 1, 5, 4);

        expect_bus(32'h304, 1'b0, 4'b1111, 32'h0);
        cur_ld = 32'h13579BDF; expect_resp(cur_ld, 1'b0, 1'b0);
        do_op("wait3", 1, 0, 3'b010, 32'h304, 32'h0, 32'h13579BDF, 3, 0, 5, 4);

        // Start with no direction must be ignored.
        @(posedge clk);
        #1;
        start = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        #1;
        chk("noop_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        start = 1'b0;
        #1;
        chk("noop_stays_idle", {30'h0, busy, bus_req}, 32'h0);

        // Reset in the middle of a request.
        expect_bus(32'h400, 1'b0, 4'b1111, 32'h0);
        @(posedge clk);
        #1;
        hold_low = 1'b1;
        start = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400;
        @(posedge clk);
        #1;
        start = 1'b0; mem_read = 1'b0;
        @(posedge clk);
        #2;
        chk("pre_reset_req", 32'(bus_req), 32'h1);
        reset = 1'b1;
        #1;
        chk("reset_mid_req", 32'(bus_req), 32'h0);
        chk("reset_mid_busy", 32'(busy), 32'h0);
        chk("reset_mid_done", 32'(done), 32'h0);
        chk("reset_mid_load_data", load_data, 32'h0);
        hold_low = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        expect_bus(32'h404, 1'b0, 4'b1111, 32'h0);
        cur_ld = 32'h0BADF00D; expect_resp(cur_ld, 1'b0, 1'b0);
        do_op("after_reset_lw", 1, 0, 3'b010, 32'h404, 32'h0, 32'h0BADF00D, 0, 0, 2, 1);

        repeat (4) @(posedge clk);
        #2;
        chk("resp_queue_empty", 32'(resp_q.size()), 32'h0);
        chk("bus_queue_empty", 32'(bus_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
